boot_loader: RTL
================

BOOT_LOADER -- requirements
Module: boot_loader

Interface
REQ-001 Parameter DW, default 32, SHALL set the memory word width in bits; it is a multiple of 8, range 8..64.
REQ-002 Parameter AW, default 12, SHALL set the memory word-address width.
REQ-003 Parameter END_WORD, default 'h0000_0FFF (DW bits), SHALL be the terminator word; receiving it ends the load and it is never written.
REQ-004 Parameter TIMEOUT, default 100000, SHALL be the maximum idle cycles allowed between bytes of a partial word.
REQ-005 clk_i  in  1  single clock; all state changes on its rising edge.
REQ-006 rst_i  in  1  asynchronous, active-high reset.
REQ-007 prog_i  in  1  level input; a rising edge starts a load, a low level aborts or re-arms.
REQ-008 rx_dv_i  in  1  one-cycle strobe marking rx_byte_i valid.
REQ-009 rx_byte_i  in  8  received byte.
REQ-010 we_o  out  1  memory write strobe, one cycle per word.
REQ-011 addr_o  out  AW  memory word address.
REQ-012 wdata_o  out  DW  memory write data.
REQ-013 prog_rst_no  out  1  active-low system reset; held low while loading.
REQ-014 done_o  out  1  load finished, either normally or by error.
REQ-015 err_o  out  1  sticky error: timeout, overflow or abort.
REQ-016 word_cnt_o  out  AW+1  number of words written in the current load.

Function
REQ-017 FSM states SHALL be IDLE, RECV, WRITE and DONE; all outputs SHALL be registered.
REQ-018 IDLE: prog_rst_no=1; a prog_i 0->1 edge (against a registered copy of prog_i) -> RECV; entering RECV clears the byte index, address pointer, word_cnt_o, err_o and done_o, and drives prog_rst_no=0.
REQ-019 RECV: each rx_dv_i stores rx_byte_i into bits [8k+7:8k] of the assembly register (little-endian), where k is the byte index 0..DW/8-1, then increments k.
REQ-020 RECV: the rx_dv_i carrying byte k=DW/8-1 -> WRITE on the next edge, with k wrapping to 0.
REQ-021 WRITE, word==END_WORD: -> DONE with no write.
REQ-022 WRITE, any other word: we_o=1, addr_o=pointer, wdata_o=word for exactly this one cycle; pointer and word_cnt_o increment; state -> RECV.
REQ-023 Write latency: we_o SHALL be high in the cycle immediately after the clock edge that samples the final byte's rx_dv_i.
REQ-024 rx_dv_i asserted during WRITE SHALL be captured as byte 0 of the next word, with k=1 after WRITE; no byte is ever dropped.
REQ-025 Overflow: a write issued at pointer 2^AW-1 completes normally, then -> DONE with err_o=1; the pointer does not wrap.
REQ-026 Timeout: in RECV with k!=0, TIMEOUT consecutive cycles without rx_dv_i -> DONE with err_o=1; the partial word is discarded.
REQ-027 The idle counter SHALL reset on every rx_dv_i and SHALL not run while k==0.
REQ-028 Abort: prog_i=0 in RECV or WRITE -> IDLE with err_o=1 and prog_rst_no=1; an in-progress WRITE-cycle write still completes, and no further writes occur.
REQ-029 DONE: prog_rst_no=1 and done_o=1; prog_i low -> IDLE with done_o=0 and err_o held; a new load requires a new rising edge.
REQ-030 Outside WRITE, we_o SHALL be 0 and addr_o/wdata_o SHALL hold their last values.

Reset
REQ-031 On rst_i=1, the block SHALL immediately enter IDLE with we_o=0, addr_o=0, wdata_o=0, prog_rst_no=1, done_o=0, err_o=0, word_cnt_o=0, k=0 and the registered prog_i=0.
REQ-032 Reset mid-load SHALL abandon the load without a write; prog_i held high through reset release SHALL NOT start a load.

Verification
REQ-033 Defaults; prog_i rise; bytes 78,56,34,12,EF,BE,AD,DE,FF,0F,00,00 -> writes (0,12345678),(1,DEADBEEF); done_o=1; word_cnt_o=2; err_o=0; prog_rst_no low between start and DONE.
REQ-034 Two bytes, then 100000 idle cycles -> DONE, err_o=1, no write, word_cnt_o=0.
REQ-035 AW=2, five non-terminator words -> writes at addr 0..3, then DONE with err_o=1; the fifth word is not written.
REQ-036 Final byte rx_dv_i followed by rx_dv_i in the WRITE cycle -> one write, and the second byte lands at bits [7:0] of the next word.
REQ-037 prog_i dropped after 3 bytes of word 1 -> IDLE, err_o=1, prog_rst_no=1, only word 0 written; a new prog_i rise clears err_o.
REQ-038 DW=16, END_WORD='hFFFF; bytes 34,12,FF,FF -> single write (0,1234) then DONE.

Source files
------------

// File: rtl/boot_loader_if.sv
// Boot loader bus: host-side byte stream and program control in, memory write port and status out.
//   prog_i       level: rising edge starts a load, low aborts/re-arms
//   rx_dv_i      one-cycle strobe qualifying rx_byte_i
//   rx_byte_i    received byte
//   we_o         memory write strobe, one cycle per word
//   addr_o       memory word address
//   wdata_o      memory write data
//   prog_rst_no  active-low system reset, low while loading
//   done_o       load finished (normally or by error)
//   err_o        sticky error (timeout, overflow, abort)
//   word_cnt_o   words written in the current load
interface boot_loader_if #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 12
);
    logic          prog_i;
    logic          rx_dv_i;
    logic [7:0]    rx_byte_i;
    logic          we_o;
    logic [AW-1:0] addr_o;
    logic [DW-1:0] wdata_o;
    logic          prog_rst_no;
    logic          done_o;
    logic          err_o;
    logic [AW:0]   word_cnt_o;

    // Host / byte-source side
    modport master (
        output prog_i, rx_dv_i, rx_byte_i,
        input  we_o, addr_o, wdata_o, prog_rst_no, done_o, err_o, word_cnt_o
    );

    // Loader side
    modport slave (
        input  prog_i, rx_dv_i, rx_byte_i,
        output we_o, addr_o, wdata_o, prog_rst_no, done_o, err_o, word_cnt_o
    );
endinterface

// File: rtl/boot_loader.sv
// Boot loader: assembles little-endian words from a byte stream and writes them to
// consecutive memory addresses until a terminator word, timeout, overflow or abort.
//   clk_i   single clock, rising edge
//   rst_i   asynchronous active-high reset
//   bus     boot_loader_if.slave (byte stream in, memory write port and status out)
module boot_loader #(
    parameter int unsigned   DW       = 32,
    parameter int unsigned   AW       = 12,
    parameter logic [DW-1:0] END_WORD = DW'('h0000_0FFF),
    parameter int unsigned   TIMEOUT  = 100000
) (
    input  logic         clk_i,
    input  logic         rst_i,
    boot_loader_if.slave bus
);

    localparam int unsigned NB = DW / 8;
    localparam int unsigned KW = (NB > 1) ? $clog2(NB) : 1;
    localparam int unsigned IW = $clog2(TIMEOUT + 1);

    localparam logic [KW-1:0] K_LAST    = KW'(NB - 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);
    localparam logic [AW-1:0] PTR_LAST  = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic          prog_q, prog_d;
    logic          armed_q, armed_d;
    logic [KW-1:0] k_q, k_d;
    logic [DW-1:0] asm_q, asm_d;
    logic [IW-1:0] idle_q, idle_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          prst_n_q, prst_n_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [DW-1:0] ins_word;

    // Assembly register with the current byte dropped into lane k
    always_comb begin
        ins_word = asm_q;
        for (int unsigned i = 0; i < NB; i++) begin
            if (k_q == KW'(i)) begin
                ins_word[8*i +: 8] = bus.rx_byte_i;
            end
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d  = state_q;
        prog_d   = bus.prog_i;
        // A low level must be seen after reset/load before a rising edge counts
        armed_d  = armed_q | ~bus.prog_i;
        k_d      = k_q;
        asm_d    = asm_q;
        idle_d   = idle_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        prst_n_d = prst_n_q;
        done_d   = done_q;
        err_d    = err_q;
        cnt_d    = cnt_q;

        unique case (state_q)
            S_IDLE: begin
                prst_n_d = 1'b1;
                if (bus.prog_i && !prog_q && armed_q) begin
                    state_d  = S_RECV;
                    armed_d  = 1'b0;
                    k_d      = '0;
                    idle_d   = '0;
                    cnt_d    = '0;
                    err_d    = 1'b0;
                    done_d   = 1'b0;
                    prst_n_d = 1'b0;
                end
            end

            S_RECV: begin
                if (!bus.prog_i) begin
                    state_d  = S_IDLE;
                    err_d    = 1'b1;
                    prst_n_d = 1'b1;
                    k_d      = '0;
                end else if (bus.rx_dv_i) begin
                    asm_d  = ins_word;
                    idle_d = '0;
                    if (k_q == K_LAST) begin
                        // Write strobe is issued on this edge so it is high during WRITE
                        k_d     = '0;
                        state_d = S_WRITE;
                        if (ins_word != END_WORD) begin
                            we_d    = 1'b1;
                            addr_d  = cnt_q[AW-1:0];
                            wdata_d = ins_word;
                        end
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end else if (k_q != '0) begin
                    if (idle_q == IDLE_LAST) begin
                        state_d  = S_DONE;
                        done_d   = 1'b1;
                        err_d    = 1'b1;
                        prst_n_d = 1'b1;
                        k_d      = '0;
                        idle_d   = '0;
                    end else begin
                        idle_d = idle_q + IW'(1);
                    end
                end
            end

            S_WRITE: begin
                // we_q low here means the word was the terminator
                idle_d = '0;
                if (we_q) begin
                    cnt_d = cnt_q + (AW+1)'(1);
                end
                if (!bus.prog_i) begin
                    state_d  = S_IDLE;
                    err_d    = 1'b1;
                    prst_n_d = 1'b1;
                end else if (!we_q) begin
                    state_d  = S_DONE;
                    done_d   = 1'b1;
                    prst_n_d = 1'b1;
                end else if (cnt_q[AW-1:0] == PTR_LAST) begin
                    state_d  = S_DONE;
                    done_d   = 1'b1;
                    err_d    = 1'b1;
                    prst_n_d = 1'b1;
                end else begin
                    state_d = S_RECV;
                    if (bus.rx_dv_i) begin
                        asm_d[7:0] = bus.rx_byte_i;
                        k_d        = KW'(1);
                    end
                end
            end

            S_DONE: begin
                prst_n_d = 1'b1;
                done_d   = 1'b1;
                if (!bus.prog_i) begin
                    state_d = S_IDLE;
                    done_d  = 1'b0;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            prog_q   <= 1'b0;
            armed_q  <= 1'b0;
            k_q      <= '0;
            asm_q    <= '0;
            idle_q   <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            prst_n_q <= 1'b1;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            prog_q   <= prog_d;
            armed_q  <= armed_d;
            k_q      <= k_d;
            asm_q    <= asm_d;
            idle_q   <= idle_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            prst_n_q <= prst_n_d;
            done_q   <= done_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.we_o        = we_q;
    assign bus.addr_o      = addr_q;
    assign bus.wdata_o     = wdata_q;
    assign bus.prog_rst_no = prst_n_q;
    assign bus.done_o      = done_q;
    assign bus.err_o       = err_q;
    assign bus.word_cnt_o  = cnt_q;

endmodule
